// File: rtl/instr_mem_pkg.sv
// Shared constants and enums for the synchronous instruction memory.
// The fault code values are visible on rsp_fault.
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

endpackage

// File: rtl/imem_array.sv
// DEPTH_WORDS x 32 storage: one synchronous read port and one byte-enabled write port.
// A read and a write to the same word in one cycle return the old word (read-first).
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [3:0]       wr_be,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // No reset on storage or read register; contents come from the INIT fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Instruction memory with NOP fill at reset, fetch port with stall/flush,
// address fault decode and byte-enabled load port.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int          ADDR_W      = 20,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_WORD    = NOP_INSTR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           req_ready,
  input  logic                           stall,
  input  logic                           flush,
  output logic                           rsp_valid,
  output logic [31:0]                    rsp_instr,
  output logic [ADDR_W-1:0]              rsp_addr,
  output logic [1:0]                     rsp_fault,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [3:0]                     ld_be,
  input  logic [31:0]                    ld_data,
  output logic                           init_done
);

  localparam int               IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH_WORDS - 1);

  state_e           state, state_next;
  logic [IDX_W-1:0] fill_cnt;
  logic             accept;
  fault_e           req_fault;
  fault_e           rsp_fault_q;
  logic             rsp_use_mem;
  logic [31:0]      rd_data;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      fill_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && fill_cnt == LAST_IDX) state_next = ST_READY;
  end

  assign init_done = (state == ST_READY);
  assign req_ready = (state == ST_READY) & ~stall;
  assign accept    = req_valid & req_ready & ~flush;

  // Misaligned is checked first so it wins over out-of-range.
  always_comb begin
    req_fault = FAULT_NONE;
    if (req_addr[1:0] != 2'b00)               req_fault = FAULT_MISALIGN;
    else if ({1'b0, req_addr} >= ADDR_LIMIT)  req_fault = FAULT_RANGE;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ld_addr;
    wr_be   = ld_be;
    wr_data = ld_data;
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_addr = fill_cnt;
      wr_be   = 4'hF;
      wr_data = NOP_WORD;
    end else begin
      wr_en   = ld_en;
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_be   (wr_be),
    .wr_data (wr_data),
    .rd_en   (accept && req_fault == FAULT_NONE),
    .rd_addr (req_addr[IDX_W+1:2]),
    .rd_data (rd_data)
  );

  // The array read register only moves on an accepted fetch, so stall holds it too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_addr    <= '0;
      rsp_fault_q <= FAULT_NONE;
      rsp_use_mem <= 1'b0;
    end else if (flush) begin
      rsp_valid   <= 1'b0;
    end else if (!stall) begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_addr    <= req_addr;
        rsp_fault_q <= req_fault;
        rsp_use_mem <= (req_fault == FAULT_NONE);
      end
    end
  end

  assign rsp_instr = rsp_use_mem ? rd_data : NOP_WORD;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Randomized and directed bench for instr_mem_sync with a word-array reference model.
module tb_instr_mem_sync;

  localparam int          ADDR_W = 20;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              stall;
  logic              flush;
  logic              rsp_valid;
  logic [31:0]       rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_fault;
  logic              ld_en;
  logic [3:0]        ld_addr;
  logic [3:0]        ld_be;
  logic [31:0]       ld_data;
  logic              init_done;

  int vectors    = 0;
  int miscompares = 0;

  int          fill_m;
  logic [31:0] mem_m [DEPTH];
  logic        e_valid;
  logic [31:0] e_instr;
  logic [31:0] e_addr;
  logic [1:0]  e_fault;

  instr_mem_sync #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .NOP_WORD    (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .stall     (stall),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_be     (ld_be),
    .ld_data   (ld_data),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResponse();
    checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_valid});
    checkOutput("rsp_instr", rsp_instr, e_instr);
    checkOutput("rsp_addr",  {12'b0, rsp_addr}, e_addr);
    checkOutput("rsp_fault", {30'b0, rsp_fault}, {30'b0, e_fault});
    checkOutput("init_done", {31'b0, init_done}, {31'b0, (fill_m >= DEPTH)});
  endtask

  // Asynchronous reset pulse; outputs are checked before any clock edge arrives.
  task automatic doReset();
    req_valid = 1'b0; req_addr = '0; stall = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_be = '0; ld_data = '0;
    rst = 1'b1;
    fill_m  = 0;
    e_valid = 1'b0; e_instr = NOP; e_addr = '0; e_fault = 2'b00;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
    #1;
    checkResponse();
    checkOutput("req_ready_rst", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict with the model, then compare.
  task automatic applyStimulus(input logic rv, input logic [ADDR_W-1:0] ra, input logic st,
                               input logic fl, input logic le, input logic [3:0] la,
                               input logic [3:0] lb, input logic [31:0] ld);
    logic ready_m;
    req_valid = rv; req_addr = ra; stall = st; flush = fl;
    ld_en = le; ld_addr = la; ld_be = lb; ld_data = ld;
    #1;
    ready_m = (fill_m >= DEPTH);
    checkOutput("req_ready", {31'b0, req_ready}, {31'b0, ready_m && !st});
    if (fl) begin
      e_valid = 1'b0;
    end else if (!st) begin
      if (ready_m && rv) begin
        e_valid = 1'b1;
        e_addr  = {12'b0, ra};
        if (ra % 4 != 0) begin
          e_fault = 2'b01; e_instr = NOP;
        end else if (ra >= 4 * DEPTH) begin
          e_fault = 2'b10; e_instr = NOP;
        end else begin
          e_fault = 2'b00; e_instr = mem_m[ra / 4];
        end
      end else begin
        e_valid = 1'b0;
      end
    end
    if (ready_m && le) begin
      for (int b = 0; b < 4; b++) if (lb[b]) mem_m[la][8*b +: 8] = ld[8*b +: 8];
    end
    @(posedge clk); #1;
    if (fill_m < DEPTH) fill_m++;
    checkResponse();
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] ra);
    applyStimulus(1'b1, ra, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
  endtask

  task automatic idle(input logic st, input logic fl);
    applyStimulus(1'b0, '0, st, fl, 1'b0, 4'd0, 4'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    doReset();

    // Fill phase with junk loads and fetches that must be ignored.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, ADDR_W'(4 * i), 1'b0, 1'b0, 1'b1, 4'(i), 4'hF, $urandom);

    for (int i = 0; i < DEPTH; i++) fetch(ADDR_W'(4 * i));
    idle(1'b0, 1'b0);

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0, 4'hF, 32'h00A00213);
    fetch('0);
    fetch(20'h2);
    fetch(20'h40);
    fetch(20'h43);
    fetch(20'h3C);

    fetch('0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 20'h8, 1'b1, 1'b0, 1'b0, 4'd0, 4'h0, 32'h0);
    applyStimulus(1'b1, 20'h8, 1'b1, 1'b1, 1'b0, 4'd0, 4'h0, 32'h0);
    applyStimulus(1'b1, 20'h8, 1'b0, 1'b1, 1'b0, 4'd0, 4'h0, 32'h0);

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd1, 4'hF, 32'h1234_5678);
    applyStimulus(1'b1, 20'h4, 1'b0, 1'b0, 1'b1, 4'd1, 4'h1, 32'h0000_00FF);
    fetch(20'h4);

    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] ra;
      ra = ADDR_W'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 99) < 15) ra = ra + ADDR_W'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 99) < 70, ra,
                    $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 30, 4'($urandom_range(0, DEPTH - 1)),
                    4'($urandom_range(0, 15)), $urandom);
    end

    // Reset in the middle of the fill restarts it from index 0.
    doReset();
    for (int i = 0; i < 7; i++) idle(1'b0, 1'b0);
    doReset();
    for (int i = 0; i < DEPTH; i++) idle(1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) fetch(ADDR_W'(4 * i));
    idle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
